// File: rtl/credit_bp_rx_pkg.sv
// Shared types and defaults for the credit-based backpressure receive port.
// Flits travel between modules flattened as {last, addr, data}.
package credit_bp_rx_pkg;

   localparam int unsigned DEFAULT_VC_W          = 2;
   localparam int unsigned DEFAULT_D_W           = 32;
   localparam int unsigned DEFAULT_A_W           = 4;
   localparam int unsigned DEFAULT_VC_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [DEFAULT_A_W-1:0] addr;
   } routeinfo_s;

   typedef struct packed {
      logic                   last;
      logic [DEFAULT_D_W-1:0] data;
   } payload_s;

   typedef struct packed {
      routeinfo_s routeinfo;
      payload_s   payload;
   } noc_packet_s;

   localparam int unsigned DEFAULT_FLIT_W = DEFAULT_A_W + DEFAULT_D_W + 1;

   // Reorders the structured packet into the flat {last, addr, data} flit layout.
   function automatic logic [DEFAULT_FLIT_W-1:0] flit_of(input noc_packet_s p);
      return {p.payload.last, p.routeinfo.addr, p.payload.data};
   endfunction

   // Index width that stays legal for a single-entry array.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/credit_bp_rx_fifo.sv
// Single-VC synchronous FIFO holding DEPTH-1 flits. The head reads as zero when
// empty, so nothing stale is ever presented downstream.
module credit_bp_rx_fifo
   import credit_bp_rx_pkg::*;
#(
   parameter int unsigned W     = DEFAULT_FLIT_W,
   parameter int unsigned DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int unsigned Entries = DEPTH - 1;
   localparam int unsigned IdxW    = idx_w(Entries);
   localparam int unsigned CntW    = $clog2(DEPTH);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Entries - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(Entries);

   logic [W-1:0]    mem_q [Entries];
   logic [IdxW-1:0] wr_q, wr_d;
   logic [IdxW-1:0] rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == FullCnt);
   assign empty_o = (cnt_q == '0);
   // A push into a full FIFO is dropped even if a pop happens in the same cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         wr_d = (wr_q == LastIdx) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = (rd_q == LastIdx) ? '0 : rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   assign head_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/credit_bp_rx.sv
// Receive end of the credit-based NoC link: per-VC FIFOs feeding the switch and
// one registered credit pulse returned to the transmitter per dequeued flit.
module credit_bp_rx
   import credit_bp_rx_pkg::*;
#(
   parameter int unsigned VC_W  = DEFAULT_VC_W,
   parameter int unsigned D_W   = DEFAULT_D_W,
   parameter int unsigned A_W   = DEFAULT_A_W,
   parameter int unsigned DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [VC_W-1:0]            vc_target_i,
   input  logic [A_W+D_W:0]           packet_i,
   output logic [VC_W-1:0]            vc_credit_gnt_o,
   output logic [VC_W-1:0]            o_v,
   output logic [VC_W*(A_W+D_W+1)-1:0] o_d,
   input  logic [VC_W-1:0]            i_b
);

   localparam int unsigned FlitW = A_W + D_W + 1;

   logic [VC_W-1:0] full, empty, pop, push;
   logic [VC_W-1:0] gnt_q, gnt_d;
   logic            target_ok;

   // Multi-hot targets are a protocol violation; write nothing in that case.
   assign target_ok = ((vc_target_i & (vc_target_i - VC_W'(1))) == '0);
   assign push      = target_ok ? vc_target_i : '0;

   for (genvar v = 0; v < VC_W; v++) begin : g_vc
      credit_bp_rx_fifo #(
         .W     (FlitW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[v]),
         .wdata_i (packet_i),
         .pop_i   (pop[v]),
         .full_o  (full[v]),
         .empty_o (empty[v]),
         .head_o  (o_d[v*FlitW +: FlitW])
      );

      assign o_v[v] = ~empty[v];
      assign pop[v] = ~empty[v] & ~i_b[v];

`ifndef SYNTHESIS
      a_no_overflow : assert property (@(posedge clk) disable iff (rst)
         !(vc_target_i[v] && full[v]))
         else $error("credit_bp_rx: overflow on VC %0d", v);
`endif
   end

   assign gnt_d = pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q <= '0;
      end else begin
         gnt_q <= gnt_d;
      end
   end

   assign vc_credit_gnt_o = gnt_q;

`ifndef SYNTHESIS
   a_onehot_target : assert property (@(posedge clk) disable iff (rst) target_ok)
      else $error("credit_bp_rx: multi-hot vc_target %b", vc_target_i);
`endif

endmodule

// File: tb/tb_credit_bp_rx.sv
// Directed bench for credit_bp_rx: a queue-per-VC reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_credit_bp_rx;

   localparam int unsigned VC_W  = 2;
   localparam int unsigned A_W   = 4;
   localparam int unsigned D_W   = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FW    = A_W + D_W + 1;
   localparam int unsigned CAP   = DEPTH - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [VC_W-1:0]      vc_target;
   logic [FW-1:0]        packet;
   logic [VC_W-1:0]      gnt;
   logic [VC_W-1:0]      ov;
   logic [VC_W*FW-1:0]   od;
   logic [VC_W-1:0]      ib;

   int n_cmp = 0;
   int n_err = 0;

   credit_bp_rx #(
      .VC_W  (VC_W),
      .D_W   (D_W),
      .A_W   (A_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .vc_target_i     (vc_target),
      .packet_i        (packet),
      .vc_credit_gnt_o (gnt),
      .o_v             (ov),
      .o_d             (od),
      .i_b             (ib)
   );

   always #5 clk = ~clk;

   // Reference model: each VC is a plain queue of flits.
   logic [FW-1:0]      q [VC_W][$];
   logic [VC_W-1:0]    m_ov;
   logic [VC_W*FW-1:0] m_od;
   logic [VC_W-1:0]    m_gnt;
   logic               model_ok = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_W; v++) q[v].delete();
         m_gnt    = '0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         for (int v = 0; v < VC_W; v++) begin
            m_gnt[v] = (q[v].size() > 0) && !ib[v];
            if (m_gnt[v]) void'(q[v].pop_front());
         end
         if ($countones(vc_target) == 1) begin
            for (int v = 0; v < VC_W; v++) begin
               if (vc_target[v] && q[v].size() < CAP) q[v].push_back(packet);
            end
         end
      end
      for (int v = 0; v < VC_W; v++) begin
         m_ov[v]            = q[v].size() > 0;
         m_od[v*FW +: FW]   = (q[v].size() > 0) ? q[v][0] : '0;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         check("model o_v", 128'(ov), 128'(m_ov));
         check("model o_d", 128'(od), 128'(m_od));
         check("model gnt", 128'(gnt), 128'(m_gnt));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [FW-1:0] mk(input logic last, input logic [A_W-1:0] a,
                                        input logic [D_W-1:0] d);
      return {last, a, d};
   endfunction

   int cnt11;
   int seen_other;

   initial begin
      rst       = 1'b1;
      vc_target = '0;
      packet    = '0;
      ib        = '0;
      step();
      step();
      rst = 1'b0;

      // 1: idle after reset
      for (int i = 0; i < 4; i++) begin
         step();
         check("idle o_v", 128'(ov), 128'd0);
         check("idle gnt", 128'(gnt), 128'd0);
      end

      // 2: single flit, popped immediately
      vc_target = 2'b01;
      packet    = mk(1'b1, 4'h3, 32'h1234_4321);
      step();
      vc_target = '0;
      packet    = '0;
      check("t2 o_v", 128'(ov), 128'd1);
      check("t2 o_d0", 128'(od[FW-1:0]), 128'h1_3_1234_4321);
      step();
      check("t2 gnt pulse", 128'(gnt), 128'd1);
      check("t2 o_v empty", 128'(ov), 128'd0);
      step();
      check("t2 gnt end", 128'(gnt), 128'd0);

      // 3: fill both VCs under full backpressure
      ib = 2'b11;
      for (int ii = 0; ii < CAP; ii++) begin
         vc_target = 2'b01;
         packet    = mk(1'b0, 4'h0, 32'(ii * 123));
         step();
         check("t3 gnt vc0", 128'(gnt), 128'd0);
      end
      for (int ii = 0; ii < CAP; ii++) begin
         vc_target = 2'b10;
         packet    = mk(1'b0, 4'h0, 32'(ii * 456));
         step();
         check("t3 gnt vc1", 128'(gnt), 128'd0);
      end
      vc_target = '0;
      packet    = '0;
      step();
      check("t3 o_v full", 128'(ov), 128'd3);
      check("t3 o_d held", 128'(od), 128'd0);

      // 4: release and drain both
      ib         = 2'b00;
      cnt11      = 0;
      seen_other = 0;
      for (int i = 0; i < CAP + 3; i++) begin
         step();
         if (gnt == 2'b11) cnt11++;
         else if (gnt != 2'b00) seen_other++;
         if (i == 0) check("t4 second head vc1", 128'(od[2*FW-1:FW]), 128'd456);
      end
      check("t4 credit run", 128'(cnt11), 128'(CAP));
      check("t4 partial gnt", 128'(seen_other), 128'd0);
      check("t4 drained", 128'(ov), 128'd0);

      // 5: push and pop on the same cycle
      ib        = 2'b11;
      vc_target = 2'b01;
      packet    = mk(1'b0, 4'h5, 32'hAAAA_0001);
      step();
      ib        = 2'b00;
      vc_target = 2'b01;
      packet    = mk(1'b1, 4'h6, 32'hBBBB_0002);
      step();
      vc_target = '0;
      packet    = '0;
      ib        = 2'b01;
      check("t5 o_v0 kept", 128'(ov[0]), 128'd1);
      check("t5 new head", 128'(od[FW-1:0]), 128'h1_6_BBBB_0002);
      check("t5 one credit", 128'(gnt), 128'd1);
      step();
      check("t5 no 2nd credit", 128'(gnt), 128'd0);
      ib = 2'b00;
      step();
      step();

      // 6: reset with VC1 holding 3 flits
      ib = 2'b11;
      for (int ii = 0; ii < 3; ii++) begin
         vc_target = 2'b10;
         packet    = mk(1'b1, 4'(ii + 1), 32'hC0DE_0000 + 32'(ii));
         step();
      end
      vc_target = '0;
      packet    = '0;
      check("t6 pre-reset o_v", 128'(ov), 128'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      ib  = 2'b00;
      check("t6 reset o_v", 128'(ov), 128'd0);
      check("t6 reset gnt", 128'(gnt), 128'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6 no stale o_v", 128'(ov), 128'd0);
         check("t6 no stale o_d", 128'(od), 128'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
